// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock sequencer: state encodings,
// parameter defaults and the counter width helper.
package pll_ctrl_pkg;

  localparam int unsigned HOLD_CYCLES_DEF    = 500;
  localparam int unsigned STABLE_CYCLES_DEF  = 1024;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 50000;
  localparam int unsigned MAX_RETRIES_DEF    = 3;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } pll_state_e;

  // Width of the shared cycle counter: clog2 of the longest phase, never below 1.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into clk.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; both clear on reset so no stale lock is trusted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: holds the PLL in reset, waits for a stable lock,
// releases the downstream reset, and retries or gives up on timeouts.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned MAX_RETRIES    = MAX_RETRIES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       out_reset_n,
  output logic [2:0] state,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic       failed
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             lk;
  logic             last_retry;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pll_locked),
    .q_o     (lk)
  );

  assign last_retry = ((32'(retry_q) + 32'd1) == MAX_RETRIES);

  // Next-state, retry and lock-loss bookkeeping; relock_req overrides everything.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (relock_req) begin
      state_d = ST_HOLD;
      retry_d = 2'd0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (lk) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_q + 2'd1;
            state_d = last_retry ? ST_FAIL : ST_HOLD;
          end
        end
        ST_STABLE: begin
          if (!lk) begin
            state_d = ST_WAIT;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = 2'd0;
          end
        end
        ST_RUN: begin
          if (!lk) begin
            state_d = ST_HOLD;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  // Shared cycle counter: cleared on every state entry, frozen in RUN and FAIL.
  always_comb begin
    cnt_d = cnt_q;
    if (relock_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_HOLD) || (state_q == ST_WAIT) || (state_q == ST_STABLE)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and counter registers; reset restarts a full HOLD period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      retry_q <= 2'd0;
      loss_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  assign pll_rst       = (state_q == ST_HOLD) || (state_q == ST_FAIL);
  assign out_reset_n   = (state_q == ST_RUN);
  assign failed        = (state_q == ST_FAIL);
  assign state         = state_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with a behavioural model.
module tb_pll_lock_sequencer;

  localparam int HOLD    = 4;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 20;
  localparam int RETRIES = 2;

  localparam int P_HOLD   = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAIL   = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       out_reset_n;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic       failed;

  int checksTotal = 0;
  int checksPassed = 0;

  int       mPhase;
  int       mElapsed;
  int       mRetry;
  int       mLoss;
  bit [1:0] mSync;

  pll_lock_sequencer #(
    .HOLD_CYCLES    (HOLD),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRIES    (RETRIES)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .out_reset_n   (out_reset_n),
    .state         (state),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt),
    .failed        (failed)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
  endtask

  // Model returns to its power-on condition.
  task automatic modelReset();
    mPhase   = P_HOLD;
    mElapsed = 0;
    mRetry   = 0;
    mLoss    = 0;
    mSync    = 2'b00;
  endtask

  // One clock of the behavioural model; lk is the lock flag seen two clocks late.
  task automatic modelStep(input bit locked, input bit relock);
    bit lk;
    int nextPhase;
    lk = mSync[1];
    nextPhase = mPhase;
    if (relock) begin
      nextPhase = P_HOLD;
      mRetry = 0;
    end else if (mPhase == P_HOLD) begin
      if (mElapsed + 1 >= HOLD) nextPhase = P_WAIT;
    end else if (mPhase == P_WAIT) begin
      if (lk) nextPhase = P_STABLE;
      else if (mElapsed + 1 >= TIMEOUT) begin
        mRetry = mRetry + 1;
        nextPhase = (mRetry >= RETRIES) ? P_FAIL : P_HOLD;
      end
    end else if (mPhase == P_STABLE) begin
      if (!lk) nextPhase = P_WAIT;
      else if (mElapsed + 1 >= STABLE) begin
        nextPhase = P_RUN;
        mRetry = 0;
      end
    end else if (mPhase == P_RUN) begin
      if (!lk) begin
        nextPhase = P_HOLD;
        mLoss = (mLoss >= 255) ? 255 : mLoss + 1;
      end
    end
    mElapsed = (relock || nextPhase != mPhase) ? 0 : mElapsed + 1;
    mPhase   = nextPhase;
    mSync    = {mSync[0], locked};
  endtask

  // Compare every DUT output against the model.
  task automatic compareAll();
    checkOutput("state", 32'(state), mPhase);
    checkOutput("pll_rst", 32'(pll_rst), (mPhase == P_HOLD || mPhase == P_FAIL) ? 1 : 0);
    checkOutput("out_reset_n", 32'(out_reset_n), (mPhase == P_RUN) ? 1 : 0);
    checkOutput("failed", 32'(failed), (mPhase == P_FAIL) ? 1 : 0);
    checkOutput("retry_cnt", 32'(retry_cnt), mRetry);
    checkOutput("lock_loss_cnt", 32'(lock_loss_cnt), mLoss);
  endtask

  // Drive one cycle of inputs, advance the model, sample on the falling edge.
  task automatic applyStimulus(input bit locked, input bit relock);
    pll_locked = locked;
    relock_req = relock;
    modelStep(locked, relock);
    @(posedge clk);
    @(negedge clk);
    relock_req = 1'b0;
    compareAll();
  endtask

  // Hold the lock input steady until the model reaches a phase/count, bounded.
  task automatic runUntil(input bit locked, input int phase, input int elapsed,
                          input int budget, input string tag);
    int n;
    n = 0;
    while (!(mPhase == phase && mElapsed == elapsed) && n < budget) begin
      applyStimulus(locked, 1'b0);
      n++;
    end
    checkOutput(tag, (mPhase == phase && mElapsed == elapsed) ? 1 : 0, 1);
  endtask

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset state", 32'(state), P_HOLD);
    checkOutput("reset pll_rst", 32'(pll_rst), 1);
    checkOutput("reset out_reset_n", 32'(out_reset_n), 0);
    checkOutput("reset failed", 32'(failed), 0);
    reset_n = 1'b1;

    $display("[TB] clean lock");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("clean lock out_reset_n", 32'(out_reset_n), 1);

    $display("[TB] lock loss in run");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("loss count", 32'(lock_loss_cnt), 1);

    $display("[TB] glitch during stable");
    runUntil(1'b1, P_STABLE, 3, 40, "reach stable");
    applyStimulus(1'b0, 1'b0);
    runUntil(1'b1, P_RUN, 0, 40, "reach run after glitch");

    $display("[TB] never locks");
    runUntil(1'b0, P_FAIL, 0, 100, "reach fail");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("fail failed", 32'(failed), 1);

    $display("[TB] relock from fail and from run");
    applyStimulus(1'b0, 1'b1);
    runUntil(1'b1, P_RUN, 0, 60, "reach run after relock");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      bit lv;
      int len;
      lv  = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) applyStimulus(lv, ($urandom_range(0, 63) == 0));
    end

    $display("[TB] async reset during stable");
    applyStimulus(1'b1, 1'b1);
    runUntil(1'b1, P_STABLE, 2, 40, "reach stable before reset");
    checkOutput("loss before reset nonzero", (lock_loss_cnt != 8'd0) ? 1 : 0, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async state", 32'(state), P_HOLD);
    checkOutput("async pll_rst", 32'(pll_rst), 1);
    checkOutput("async out_reset_n", 32'(out_reset_n), 0);
    checkOutput("async retry_cnt", 32'(retry_cnt), 0);
    checkOutput("async lock_loss_cnt", 32'(lock_loss_cnt), 0);
    checkOutput("async failed", 32'(failed), 0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0);

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
